// File: rtl/mac_pkg.sv
// Shared MAC definitions: header geometry, EtherType codes, TX framer state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mac_pkg;

  localparam int HDR_SIZE   = 14;
  localparam int KEEP_WIDTH = 16;
  localparam int DATA_WIDTH = KEEP_WIDTH * 8;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    BODY,
    TAIL
  } mac_tx_state_t;

  // Header as it sits on the wire: dst occupies bytes 0..5, so it is the low field.
  typedef struct packed {
    logic [15:0] frameType;
    logic [47:0] srcMacAddr;
    logic [47:0] dstMacAddr;
  } macHdr_t;

endpackage

// File: rtl/mac_tx_process_if.sv
// Header descriptor, payload stream and framed output stream of the MAC TX framer.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on all three channels; slave is the framer, master its environment.
interface mac_tx_process_if
  import mac_pkg::*;
();

  logic                  wHdr_in_valid;
  logic                  wHdr_in_ready;
  logic [47:0]           bHdr_in_DstMacAddr;
  logic [47:0]           bHdr_in_SrcMacAddr;
  logic [15:0]           bHdr_in_FrameType;

  logic                  wData_in_valid;
  logic                  wData_in_ready;
  logic [DATA_WIDTH-1:0] bData_in_data;
  logic [KEEP_WIDTH-1:0] bData_in_keep;
  logic                  wData_in_last;

  logic                  wData_out_valid;
  logic                  wData_out_ready;
  logic [DATA_WIDTH-1:0] bData_out_data;
  logic [KEEP_WIDTH-1:0] bData_out_keep;
  logic                  wData_out_last;

  modport slave (
    input  wHdr_in_valid, bHdr_in_DstMacAddr, bHdr_in_SrcMacAddr, bHdr_in_FrameType,
    output wHdr_in_ready,
    input  wData_in_valid, bData_in_data, bData_in_keep, wData_in_last,
    output wData_in_ready,
    output wData_out_valid, bData_out_data, bData_out_keep, wData_out_last,
    input  wData_out_ready
  );

  modport master (
    output wHdr_in_valid, bHdr_in_DstMacAddr, bHdr_in_SrcMacAddr, bHdr_in_FrameType,
    input  wHdr_in_ready,
    output wData_in_valid, bData_in_data, bData_in_keep, wData_in_last,
    input  wData_in_ready,
    input  wData_out_valid, bData_out_data, bData_out_keep, wData_out_last,
    output wData_out_ready
  );

endinterface

// File: rtl/mac_tx_process.sv
// Ethernet TX framer: prepends the 14-byte MAC header and realigns the payload by 14 bytes.
// Latency: output beat valid one cycle after its payload beat is accepted; +1 tail beat if last beat > 2 bytes.
// Backpressure: single output register; payload ready only when that register is free, header only in IDLE.
module mac_tx_process
  import mac_pkg::*;
(
  input  logic            wClk,
  input  logic            wRst,
  mac_tx_process_if.slave bus
);

  localparam int SHIFT_BYTES = KEEP_WIDTH - HDR_SIZE;
  localparam int SHIFT_BITS  = SHIFT_BYTES * 8;

  mac_tx_state_t         state;
  macHdr_t               hdrReg;
  logic [DATA_WIDTH-1:0] prevData;
  logic [KEEP_WIDTH-1:0] prevKeep;
  logic [DATA_WIDTH-1:0] outData;
  logic [KEEP_WIDTH-1:0] outKeep;
  logic                  outValid;
  logic                  outLast;

  logic                  wLoad;
  logic                  wHdrAcc;
  logic                  wDataAcc;
  logic                  wBeatLoad;
  logic                  wInFitsBeat;
  logic [DATA_WIDTH-1:0] nextData;
  logic [KEEP_WIDTH-1:0] nextKeep;
  logic                  nextLast;

  // Output register can take a new beat when empty or being drained this cycle.
  assign wLoad       = !outValid || bus.wData_out_ready;
  assign bus.wHdr_in_ready  = !wRst && (state == IDLE);
  assign bus.wData_in_ready = !wRst && ((state == FIRST) || (state == BODY)) && wLoad;
  assign wHdrAcc     = bus.wHdr_in_valid && bus.wHdr_in_ready;
  assign wDataAcc    = bus.wData_in_valid && bus.wData_in_ready;
  assign wBeatLoad   = wDataAcc || ((state == TAIL) && wLoad);
  // Last input beat whose bytes all fit into the current output beat (no tail needed).
  assign wInFitsBeat = (bus.bData_in_keep[KEEP_WIDTH-1:SHIFT_BYTES] == '0);

  assign bus.wData_out_valid = outValid;
  assign bus.bData_out_data  = outData;
  assign bus.bData_out_keep  = outKeep;
  assign bus.wData_out_last  = outLast;

  // Candidate output beat: low 2 input bytes land on top of the header or the previous beat's upper 14 bytes.
  always_comb begin
    nextData = {bus.bData_in_data[SHIFT_BITS-1:0], prevData[DATA_WIDTH-1:SHIFT_BITS]};
    nextKeep = {bus.bData_in_keep[SHIFT_BYTES-1:0], prevKeep[KEEP_WIDTH-1:SHIFT_BYTES]};
    nextLast = bus.wData_in_last && wInFitsBeat;
    case (state)
      FIRST: begin
        nextData = {bus.bData_in_data[SHIFT_BITS-1:0], hdrReg};
        nextKeep = {bus.bData_in_keep[SHIFT_BYTES-1:0], {HDR_SIZE{1'b1}}};
      end
      TAIL: begin
        nextData = {{SHIFT_BITS{1'b0}}, prevData[DATA_WIDTH-1:SHIFT_BITS]};
        nextKeep = {{SHIFT_BYTES{1'b0}}, prevKeep[KEEP_WIDTH-1:SHIFT_BYTES]};
        nextLast = 1'b1;
      end
      default: ;
    endcase
  end

  // Framer FSM together with the registered output stage and the one-beat history.
  always_ff @(posedge wClk) begin
    if (wRst) begin
      state    <= IDLE;
      hdrReg   <= '0;
      prevData <= '0;
      prevKeep <= '0;
      outData  <= '0;
      outKeep  <= '0;
      outValid <= 1'b0;
      outLast  <= 1'b0;
    end else begin
      if (wBeatLoad) begin
        outData  <= nextData;
        outKeep  <= nextKeep;
        outLast  <= nextLast;
        outValid <= 1'b1;
      end else if (bus.wData_out_ready) begin
        outValid <= 1'b0;
      end

      if (wDataAcc) begin
        prevData <= bus.bData_in_data;
        prevKeep <= bus.bData_in_keep;
      end

      case (state)
        IDLE: begin
          if (wHdrAcc) begin
            hdrReg <= '{frameType:  bus.bHdr_in_FrameType,
                        srcMacAddr: bus.bHdr_in_SrcMacAddr,
                        dstMacAddr: bus.bHdr_in_DstMacAddr};
            state  <= FIRST;
          end
        end
        FIRST, BODY: begin
          if (wDataAcc) begin
            if (!bus.wData_in_last) begin
              state <= BODY;
            end else if (wInFitsBeat) begin
              state <= IDLE;
            end else begin
              state <= TAIL;
            end
          end
        end
        TAIL: begin
          if (wLoad) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mac_tx_process.md
# mac_tx_process

Ethernet MAC transmit framer: accepts a header descriptor (destination MAC, source MAC, EtherType) and a 128-bit AXI-stream payload, and emits one 128-bit AXI-stream frame with the 14-byte header prepended. The payload is re-aligned by 14 bytes across beats. The block sits between the IP/ARP TX layer and the FCS/padding stage. It is the transmit counterpart of the MAC RX header-strip path and uses the same byte ordering: byte 0 is in [7:0].

## Interface
- `HDR_SIZE`, 14, header bytes (fixed)
- `KEEP_WIDTH`, 16, bytes per beat (fixed)
- `wClk` in 1 clock
- `wRst` in 1 reset, synchronous, active-high
- `wHdr_in_valid` in 1 header descriptor valid
- `wHdr_in_ready` out 1 header accept
- `bHdr_in_DstMacAddr` in 48 destination MAC
- `bHdr_in_SrcMacAddr` in 48 source MAC
- `bHdr_in_FrameType` in 16 EtherType
- `wData_in_valid` / `wData_in_ready` in/out 1 payload handshake
- `bData_in_data` in 128 payload
- `bData_in_keep` in 16 byte enables
- `wData_in_last` in 1 end of payload
- `wData_out_valid` out 1 frame beat valid (registered)
- `wData_out_ready` in 1 downstream accept
- `bData_out_data` out 128 frame data (registered)
- `bData_out_keep` out 16 byte enables (registered)
- `wData_out_last` out 1 end of frame (registered)

## Operation
- Input keep must be contiguous from bit 0, and the payload must be at least 1 byte. Padding and FCS are added downstream.
- The FSM has four states: IDLE, FIRST, BODY, TAIL.
- **IDLE**
  - `wHdr_in_ready`=1, `wData_in_ready`=0.
  - On header handshake: latch `{type, src, dst}` as `hdr[111:0]` (dst in [47:0], src in [95:48], type in [111:96]), then go to FIRST.
- **Output register load.** "Load" means the output register is free: `!wData_out_valid || wData_out_ready`.
- **FIRST / BODY**
  - `wData_in_ready` = load.
  - On payload accept in FIRST:
    - `out_data = {in[15:0], hdr[111:0]}`
    - `out_keep = {in_keep[1:0], 14'h3FFF}`
  - On payload accept in BODY:
    - `out_data = {in[15:0], prev[127:16]}`
    - `out_keep = {in_keep[1:0], prev_keep[15:2]}`
  - On every accept: `prev`/`prev_keep` <= in, in_keep; `wData_out_valid`<=1.
  - Accepted beat not last: `wData_out_last`<=0, next state BODY.
  - Last beat with `in_keep[15:2]==0`: `wData_out_last`<=1, next state IDLE.
  - Last beat with `in_keep[15:2]!=0`: `wData_out_last`<=0, next state TAIL.
- **TAIL**
  - `wData_in_ready`=0, `wHdr_in_ready`=0.
  - On load: `out_data = {16'h0, prev[127:16]}`, `out_keep = {2'b0, prev_keep[15:2]}`, `wData_out_last`=1, next state IDLE.
- **Output register otherwise.** If no new beat is loaded and `wData_out_ready`=1, `wData_out_valid`<=0. Data, keep and last hold while `valid && !ready`.
- **Unused bytes.** Bytes outside keep are don't-care, except that TAIL zeroes the upper 2 bytes.

## Timing
- **Reset values:** `wData_out_valid`=0, `bData_out_data`=0, `bData_out_keep`=0, `wData_out_last`=0; state=IDLE.
- **Readies during reset:** `wHdr_in_ready` and `wData_in_ready` are combinational from state and the output register, and are forced to 0 while `wRst`=1.
- **Latency:** an output beat is valid in the cycle after its input payload beat is accepted.
- **Throughput:** 1 beat per cycle within a frame.
- **Per-frame overhead:**
  - +1 output beat when the last input beat carries more than 2 bytes.
  - 1 idle cycle between frames for the header accept.
  - The header may be accepted while the final beat of the previous frame is still stalled in the output register.
- **Header/payload ordering:** payload valid arriving before the header is held off (`ready`=0). A header arriving early waits in IDLE until the previous frame has completed.
- **Reset mid-frame:** the frame is discarded, outputs return to reset values on the next edge, and upstream restarts with a new header.
- AXI rules: valid never drops without a handshake, and data is stable while stalled.

## Structure
- Shared package `mac_pkg`:
  - `HDR_SIZE`=14, `KEEP_WIDTH`=16
  - `ETH_TYPE_IPV4`=16'h0800, `ETH_TYPE_ARP`=16'h0806
  - `mac_tx_state_t` enum {IDLE, FIRST, BODY, TAIL}
- One flat module; no sub-module is needed. The shift/keep muxing is inline.

## Test plan
- Header dst=48'h0A0B0C0D0E0F, src=48'h112233445566, type=16'h0800, with a 2-byte payload 16'hBEEF (keep 16'h0003, last) -> one beat:
  - keep 16'hFFFF, last=1
  - [47:0]=dst, [95:48]=src, [111:96]=16'h0800, [127:112]=16'hBEEF
- 3-byte payload, keep 16'h0007 -> two beats:
  - beat 1: keep 16'hFFFF, last=0
  - beat 2: keep 16'h0001, last=1, [7:0]=payload byte 2, [127:8]=0
- 32-byte payload (two beats of keep 16'hFFFF) -> three beats with keep FFFF/FFFF/3FFF; last only on the third; byte stream equals header followed by payload.
- 4-beat frame with `wData_out_ready` pattern 1,0,1,0,… -> output identical to the full-rate run, no drops or duplicates; `wData_in_ready`=0 whenever `valid && !out_ready`.
- Payload valid held 5 cycles before header valid -> `wData_in_ready`=0 until the cycle after the header handshake; the first output beat is correct.
- `wRst` pulsed after 2 of 4 beats are accepted -> next cycle `wData_out_valid`=0 and `wHdr_in_ready`=1; the following frame is correct.
